div_op_sequencer: RTL and testbench
===================================

# div_op_sequencer

Sequential front/back-end for the combinational 4-bit non-restoring divider. It accepts dividend/divisor pairs over a valid/ready handshake and registers them onto the divider inputs. It waits a settle cycle, then captures quotient/remainder into a small result FIFO drained by a downstream valid/ready consumer. It also handles divide-by-zero and, optionally, signed operands around the unsigned divider core.

## Interface
Parameters:
- WIDTH, 4, operand/quotient width; divider remainder input is WIDTH+1
- FIFO_DEPTH, 2, result FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer accepts operand pair
- in_x  in  WIDTH  dividend X
- in_y  in  WIDTH  divisor Y
- div_x  out  WIDTH  registered dividend to divider
- div_y  out  WIDTH  registered divisor to divider
- div_q  in  WIDTH  divider quotient Q
- div_r  in  WIDTH+1  divider remainder R (bit WIDTH is 0 after restore)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pops head
- out_q  out  WIDTH  quotient
- out_r  out  WIDTH  remainder
- out_dbz  out  1  divide-by-zero flag
- out_ovf  out  1  signed overflow flag (0 unless DIV_SIGNED_EN)

## Operation
- FSM states:
  - IDLE: in_ready = (fifo_count < FIFO_DEPTH). On in_valid&in_ready, register in_x/in_y (magnitudes if signed) onto div_x/div_y. Latch signs and dbz = (in_y == 0). Go to LAUNCH.
  - LAUNCH: divider settles for one cycle; in_ready=0. Go to CAPTURE.
  - CAPTURE: push {q, r[WIDTH-1:0], dbz, ovf} into the FIFO; in_ready=0. Go to IDLE.
- Divide-by-zero: the pushed entry is q = all ones, r = dividend (raw in_x), dbz=1, ovf=0; the divider output is ignored.
- One operation in flight; throughput 1 per 3 cycles.
- Overflow impossible: accept requires a free slot, and only pops occur until the push.
- FIFO:
  - out_valid = (count != 0). Pop on out_valid&out_ready.
  - A push in CAPTURE with a simultaneous pop is legal and leaves count unchanged.
  - No bypass: a pushed entry is visible the cycle after the push.
  - Pointers wrap modulo FIFO_DEPTH.
- out_q/out_r/out_dbz/out_ovf are forced to 0 whenever out_valid=0.
- div_x/div_y hold their value until the next accept.

## Timing
- Accept at edge E0 → div_x/div_y valid after E0 → capture/push at E2 → out_valid high after E2 (2-cycle latency) if the FIFO was empty.
- out_valid/data are held stable until popped.
- Reset values:
  - state IDLE; fifo count/pointers 0
  - in_ready 0 while rst=1, 1 in the first cycle after reset deasserts
  - div_x, div_y 0
  - out_valid, out_q, out_r, out_dbz, out_ovf all 0
- Reset mid-operation: in-flight op and all FIFO entries are discarded; no push occurs.
- in_valid while in_ready=0: ignored. The upstream side must hold the pair until it is accepted.

## Configuration
- DIV_SIGNED_EN defined:
  - in_x/in_y are two's complement. div_x/div_y are driven with magnitudes (|−2^(WIDTH−1)| = 2^(WIDTH−1) fits unsigned).
  - Quotient is negated when the operand signs differ.
  - Remainder is negated when the dividend is negative (truncating division).
  - Dividend −2^(WIDTH−1) / −1: q = −2^(WIDTH−1) (wrapped), r=0, ovf=1.
  - DBZ entry: q all ones, r = raw in_x, ovf=0.
- Not defined: operands are unsigned, no sign logic, out_ovf tied 0.

## Test plan
- Unsigned 13/3, out_ready=1 → out_valid 2 cycles after accept, q=4, r=1, dbz=0; then 15/4 → q=3, r=3.
- 9/0 → q=4'hF, r=9, dbz=1; the divider output is not used (force div_q=5 during the test).
- Backpressure, out_ready=0:
  - Issue 3 pairs: two accepted, then in_ready stays 0.
  - Assert out_ready for 1 cycle: one pop, the third pair is accepted.
  - Results emerge in order.
- Reset asserted in LAUNCH, then 7/2 issued → no stale entry; only q=3, r=1 appears; all outputs 0 during reset.
- DIV_SIGNED_EN:
  - −7/2 → q=4'b1101 (−3), r=4'b1111 (−1).
  - 7/−2 → q=−3, r=1.
  - −8/−1 → q=4'b1000, ovf=1.
- Simultaneous push/pop, FIFO_DEPTH=2 full with continuous pops → count never exceeds 2, no lost or duplicated entries over 20 random ops checked against a reference model.

Source files
------------

// File: rtl/div_op_sequencer.sv
// Sequencer around a combinational WIDTH-bit divider: operand handshake, settle cycle, result FIFO.
// Define DIV_SIGNED_EN for two's-complement operands with sign fix-up around the unsigned core.
module div_op_sequencer #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] div_x,
  output logic [WIDTH-1:0] div_y,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH:0]   div_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_dbz,
  output logic             out_ovf
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    logic             ovf;
  } res_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_div_x;
  logic [WIDTH-1:0] r_div_y;
  logic [WIDTH-1:0] r_raw_x;
  logic             r_dbz;
  res_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_next_count;
  logic [WIDTH-1:0] w_mag_x;
  logic [WIDTH-1:0] w_mag_y;
  res_t             w_result;
  res_t             w_head;
  // Remainder MSB is always 0 once the core has restored.
  logic             w_unused_r_msb;

  assign w_unused_r_msb = div_r[WIDTH];
  assign w_accept       = in_valid & r_in_ready;
  assign w_push         = (r_state == S_CAPTURE);
  assign w_pop          = r_out_valid & out_ready;
  assign w_next_count   = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_head         = r_mem[r_rd_ptr];

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic r_neg_x;
  logic r_neg_y;
  logic r_ovf_case;

  // Magnitude of the most negative value wraps to itself, which is correct unsigned.
  assign w_mag_x = in_x[WIDTH-1] ? (~in_x + WIDTH'(1)) : in_x;
  assign w_mag_y = in_y[WIDTH-1] ? (~in_y + WIDTH'(1)) : in_y;

  always_comb begin
    w_result = '0;
    if (r_dbz) begin
      w_result.q   = '1;
      w_result.r   = r_raw_x;
      w_result.dbz = 1'b1;
    end else if (r_ovf_case) begin
      w_result.q   = MIN_NEG;
      w_result.ovf = 1'b1;
    end else begin
      w_result.q = (r_neg_x ^ r_neg_y) ? (~div_q + WIDTH'(1)) : div_q;
      w_result.r = r_neg_x ? (~div_r[WIDTH-1:0] + WIDTH'(1)) : div_r[WIDTH-1:0];
    end
  end
`else
  assign w_mag_x = in_x;
  assign w_mag_y = in_y;

  always_comb begin
    w_result = '0;
    if (r_dbz) begin
      w_result.q   = '1;
      w_result.r   = r_raw_x;
      w_result.dbz = 1'b1;
    end else begin
      w_result.q = div_q;
      w_result.r = div_r[WIDTH-1:0];
    end
  end
`endif

  // Control FSM, operand registers and result FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_div_x     <= '0;
      r_div_y     <= '0;
      r_raw_x     <= '0;
      r_dbz       <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_x     <= 1'b0;
      r_neg_y     <= 1'b0;
      r_ovf_case  <= 1'b0;
`endif
    end else begin
      r_count     <= w_next_count;
      r_out_valid <= (w_next_count != '0);

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_LAUNCH;
            r_in_ready <= 1'b0;
            r_div_x    <= w_mag_x;
            r_div_y    <= w_mag_y;
            r_raw_x    <= in_x;
            r_dbz      <= (in_y == '0);
`ifdef DIV_SIGNED_EN
            r_neg_x    <= in_x[WIDTH-1];
            r_neg_y    <= in_y[WIDTH-1];
            r_ovf_case <= (in_x == MIN_NEG) && (in_y == '1);
`endif
          end else begin
            r_in_ready <= (w_next_count < CNT_W'(FIFO_DEPTH));
          end
        end
        S_LAUNCH: begin
          r_state    <= S_CAPTURE;
          r_in_ready <= 1'b0;
        end
        S_CAPTURE: begin
          r_state    <= S_IDLE;
          r_in_ready <= (w_next_count < CNT_W'(FIFO_DEPTH));
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase

      if (w_push) begin
        r_mem[r_wr_ptr] <= w_result;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign div_x     = r_div_x;
  assign div_y     = r_div_y;
  assign out_valid = r_out_valid;
  assign out_q     = r_out_valid ? w_head.q   : '0;
  assign out_r     = r_out_valid ? w_head.r   : '0;
  assign out_dbz   = r_out_valid ? w_head.dbz : 1'b0;
  assign out_ovf   = r_out_valid ? w_head.ovf : 1'b0;

endmodule

// File: tb/tb_div_op_sequencer.sv
// Scoreboard bench for div_op_sequencer; acts as the combinational divider core itself.
module tb_div_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x;
  logic [3:0] in_y;
  logic [3:0] div_x;
  logic [3:0] div_y;
  logic [3:0] div_q;
  logic [4:0] div_r;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_q;
  logic [3:0] out_r;
  logic       out_dbz;
  logic       out_ovf;

  logic       force_div = 1'b0;
  logic       mon_en = 1'b0;
  logic       rnd_on = 1'b0;
  logic [9:0] sb [$];
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  // Behavioural unsigned divider core; force_div poisons its output.
  assign div_q = force_div ? 4'd5 : ((div_y == 4'd0) ? 4'hF : (div_x / div_y));
  assign div_r = force_div ? 5'd5 : ((div_y == 4'd0) ? {1'b0, div_x} : {1'b0, div_x % div_y});

  div_op_sequencer #(.WIDTH(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .div_x(div_x), .div_y(div_y), .div_q(div_q), .div_r(div_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_dbz(out_dbz), .out_ovf(out_ovf)
  );

  function automatic logic [9:0] pk(input logic [3:0] q, input logic [3:0] r,
                                    input logic dbz, input logic ovf);
    return {q, r, dbz, ovf};
  endfunction

  // Independent reference: truncating signed or plain unsigned division.
  function automatic logic [9:0] model(input logic [3:0] x, input logic [3:0] y);
    int sx, sy;
    if (y == 4'd0) return pk(4'hF, x, 1'b1, 1'b0);
`ifdef DIV_SIGNED_EN
    if (x == 4'h8 && y == 4'hF) return pk(4'h8, 4'h0, 1'b0, 1'b1);
    sx = int'($signed(x));
    sy = int'($signed(y));
`else
    sx = int'(x);
    sy = int'(y);
`endif
    return pk(4'(sx / sy), 4'(sx % sy), 1'b0, 1'b0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send(input logic [3:0] x, input logic [3:0] y, input logic [9:0] e);
    bit done = 0;
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: pair %0h/%0h never accepted", x, y);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) @(posedge clk);
    #1;
    chk("drain_left", sb.size(), 0);
    chk("drain_valid", {31'd0, out_valid}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {in_ready, out_valid, out_q, out_r, out_dbz, out_ovf}, 0);
    chk("rst_div", {div_x, div_y}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, in_ready}, 1);
  endtask

  // Monitor: pop expected on every accepted output, require zeros when idle.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got %0h with empty scoreboard",
                     {out_q, out_r, out_dbz, out_ovf});
          end else begin
            chk("result", {out_q, out_r, out_dbz, out_ovf}, sb.pop_front());
          end
        end
      end else begin
        chk("idle_zero", {out_valid, out_q, out_r, out_dbz, out_ovf}, 0);
      end
    end
  end

  initial begin
    logic [3:0] rx, ry;
    rst = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset();

    // Basic ops with latency check.
    send(4'd13, 4'd3, pk(4'd4, 4'd1, 1'b0, 1'b0));
    @(posedge clk); #1;
    chk("lat_e1", {31'd0, out_valid}, 0);
    @(posedge clk); #1;
    chk("lat_e2", {31'd0, out_valid}, 1);
    send(4'd15, 4'd4, pk(4'd3, 4'd3, 1'b0, 1'b0));
    drain();

    // Divide by zero with a poisoned divider.
    force_div = 1'b1;
    send(4'd9, 4'd0, pk(4'hF, 4'd9, 1'b1, 1'b0));
    drain();
    force_div = 1'b0;

    // Backpressure: third pair waits for a single pop.
    out_ready = 1'b0;
    send(4'd6, 4'd2, pk(4'd3, 4'd0, 1'b0, 1'b0));
    send(4'd11, 4'd5, pk(4'd2, 4'd1, 1'b0, 1'b0));
    fork
      send(4'd14, 4'd3, pk(4'd4, 4'd2, 1'b0, 1'b0));
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("bp_ready", {31'd0, in_ready}, 0);
        chk("bp_valid", {31'd0, out_valid}, 1);
        chk("bp_head", {out_q, out_r}, {4'd3, 4'd0});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset in LAUNCH with a result already queued.
    out_ready = 1'b0;
    send(4'd2, 4'd1, pk(4'd2, 4'd0, 1'b0, 1'b0));
    send(4'd5, 4'd1, pk(4'd5, 4'd0, 1'b0, 1'b0));
    do_reset();
    out_ready = 1'b1;
    send(4'd7, 4'd2, pk(4'd3, 4'd1, 1'b0, 1'b0));
    drain();

`ifdef DIV_SIGNED_EN
    send(4'b1001, 4'd2, pk(4'b1101, 4'b1111, 1'b0, 1'b0));
    send(4'd7, 4'b1110, pk(4'b1101, 4'b0001, 1'b0, 1'b0));
    send(4'b1000, 4'b1111, pk(4'b1000, 4'b0000, 1'b0, 1'b1));
    drain();
`endif

    // Random ops against the model with random consumer stalls.
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int k = 0; k < 20; k++) begin
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      send(rx, ry, model(rx, ry));
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
